// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers: read-mode encodings and pointer width.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Pointer width: address bits plus one wrap bit (range 0..2*DEPTH-1).
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Ports:
//   clk        write clock, rising edge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  combinational read data
// Contents are not reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous read port
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// fill level, almost-full/almost-empty flags, sticky error flags and sync flush.
// Ports:
//   clk, rstn      clock (rising edge) and async active-low reset
//   wr_en/wr_data  write request and data
//   rd_en          read request (fall-through mode: pop the head word)
//   flush          sync clear of contents, overrides wr_en/rd_en
//   clr_err        sync clear of overflow/underflow
//   rd_data        read data, qualified by rd_valid
//   full_flag, empty_flag, almost_full, almost_empty, level   occupancy status
//   overflow/underflow  sticky: write while full / read while empty
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 8,
  parameter  int unsigned FWFT      = FIFO_MODE_STD,
  parameter  int unsigned AF_THRESH = 6,
  parameter  int unsigned AE_THRESH = 2,
  localparam int unsigned PW        = fifo_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = PW - 1;

  // Elaboration-time parameter checks
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > (DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_af;
  logic             r_ae;
  logic             r_ovf;
  logic             r_unf;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [PW-1:0]    w_level_nxt;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_head;

  // Accept decisions use registered flags only; flush masks both sides.
  always_comb begin
    w_wr_acc     = wr_en & ~r_full & ~flush;
    w_rd_acc     = rd_en & ~r_empty & ~flush;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      if (w_rd_acc) w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
    // Wrap bit makes the modular difference span 0..DEPTH exactly.
    w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  end

  // Pointers, level and occupancy flags, all from the next level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == PW'(DEPTH));
      r_empty  <= (w_level_nxt == '0);
      r_af     <= (w_level_nxt >= PW'(AF_THRESH));
      r_ae     <= (w_level_nxt <= PW'(AE_THRESH));
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (!flush && wr_en && r_full) r_ovf <= 1'b1;
      else if (clr_err)              r_ovf <= 1'b0;
      if (!flush && rd_en && r_empty) r_unf <= 1'b1;
      else if (clr_err)               r_unf <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_head)
  );

  // Mode-dependent read stage
  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word shown directly; forced to zero while empty so reset reads as 0.
    assign rd_valid = ~r_empty;
    assign rd_data  = r_empty ? '0 : w_head;
  end else begin : g_std
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;

    // One-cycle valid pulse per accepted read; data holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rd_valid <= 1'b0;
        r_rd_data  <= '0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= w_head;
      end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
  end

  assign full_flag    = r_full;
  assign empty_flag   = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: one standard-mode and one fall-through instance share
// the same stimulus and are checked against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] wr_data;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_level, f_level;
  logic [5:0] s_st, f_st;

  assign s_st = {s_full, s_empty, s_af, s_ae, s_ovf, s_unf};
  assign f_st = {f_full, f_empty, f_af, f_ae, f_ovf, f_unf};

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .full_flag(s_full), .empty_flag(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .level(s_level), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fwft (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .full_flag(f_full), .empty_flag(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .level(f_level), .overflow(f_ovf), .underflow(f_unf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents, sticky errors, standard-mode read register.
  logic [7:0] q[$];
  logic       m_ovf, m_unf, m_sv;
  logic [7:0] m_sd;

  function automatic logic [5:0] exp_st();
    int n;
    n = q.size();
    return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
  endfunction

  function automatic logic [3:0] exp_lvl();
    return 4'(q.size());
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_sv  = 1'b0;
    m_sd  = 8'h00;
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge, sample 1ns later.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic fl, input logic ce);
    int n;
    logic was_full, was_empty;
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r; flush = fl; clr_err = ce;
    @(posedge clk);
    n         = q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (fl) begin
      q.delete();
      m_sv = 1'b0;
    end else begin
      m_sv = r && !was_empty;
      if (m_sv) m_sd = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
    if (!fl && w && was_full)       m_ovf = 1'b1;
    else if (ce)                    m_ovf = 1'b0;
    if (!fl && r && was_empty)      m_unf = 1'b1;
    else if (ce)                    m_unf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; wr_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total++; if (s_st !== 6'b010100) begin bad++; $display("FAIL reset_std_status: got %b exp %b", s_st, 6'b010100); end
    total++; if (f_st !== exp_st()) begin bad++; $display("FAIL reset_fwft_status: got %b exp %b", f_st, exp_st()); end
    total++; if (s_level !== 4'd0 || f_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d/%0d exp 0", s_level, f_level); end
    total++; if ({s_rd_valid, s_rd_data} !== 9'h000) begin bad++; $display("FAIL reset_std_rd: got %b/%h exp 0/00", s_rd_valid, s_rd_data); end
    total++; if ({f_rd_valid, f_rd_data} !== 9'h000) begin bad++; $display("FAIL reset_fwft_rd: got %b/%h exp 0/00", f_rd_valid, f_rd_data); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      total++; if (s_level !== 4'(i)) begin bad++; $display("FAIL fill_level: got %0d exp %0d", s_level, i); end
      total++; if (s_st !== exp_st()) begin bad++; $display("FAIL fill_status: got %b exp %b", s_st, exp_st()); end
    end
    total++; if (s_full !== 1'b1 || f_full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b/%b exp 1", s_full, f_full); end
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    total++; if (s_ovf !== 1'b1 || s_level !== 4'd8) begin bad++; $display("FAIL ovf_set: got ovf=%b lvl=%0d exp 1/8", s_ovf, s_level); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (s_ovf !== 1'b0 || f_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b/%b exp 0", s_ovf, f_ovf); end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'(i)) begin bad++; $display("FAIL drain_std: got %b/%h exp 1/%h", s_rd_valid, s_rd_data, 8'(i)); end
      total++; if (f_rd_valid !== (q.size() != 0)) begin bad++; $display("FAIL drain_fwft_valid: got %b exp %b", f_rd_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL drain_fwft_data: got %h exp %h", f_rd_data, q[0]); end
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (s_rd_valid !== 1'b0 || s_rd_data !== 8'h08 || s_empty !== 1'b1) begin bad++; $display("FAIL drain_idle: got v=%b d=%h e=%b exp 0/08/1", s_rd_valid, s_rd_data, s_empty); end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      total++; if ({s_af, s_ae} !== {i >= 6, i <= 2}) begin bad++; $display("FAIL thr_up_%0d: got af=%b ae=%b", i, s_af, s_ae); end
      total++; if ({f_af, f_ae} !== {i >= 6, i <= 2}) begin bad++; $display("FAIL thr_up_fwft_%0d: got af=%b ae=%b", i, f_af, f_ae); end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (s_level !== 4'(6 - i) || {s_af, s_ae} !== {(6 - i) >= 6, (6 - i) <= 2}) begin bad++; $display("FAIL thr_dn_%0d: got lvl=%0d af=%b ae=%b", i, s_level, s_af, s_ae); end
      total++; if (s_rd_data !== m_sd) begin bad++; $display("FAIL thr_data: got %h exp %h", s_rd_data, m_sd); end
    end
    repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (s_st !== exp_st()) begin bad++; $display("FAIL thr_end: got %b exp %b", s_st, exp_st()); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] y;
    repeat (8) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    total++; if (s_level !== 4'd7 || s_ovf !== 1'b1) begin bad++; $display("FAIL sim_full: got lvl=%0d ovf=%b exp 7/1", s_level, s_ovf); end
    total++; if (s_rd_valid !== 1'b1 || s_rd_data !== m_sd) begin bad++; $display("FAIL sim_full_rd: got %b/%h exp 1/%h", s_rd_valid, s_rd_data, m_sd); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    y = 8'($urandom);
    step(1'b1, y, 1'b1, 1'b0, 1'b0);
    total++; if (s_level !== 4'd1 || s_unf !== 1'b1 || s_rd_valid !== 1'b0) begin bad++; $display("FAIL sim_empty: got lvl=%0d unf=%b v=%b exp 1/1/0", s_level, s_unf, s_rd_valid); end
    total++; if (f_rd_valid !== 1'b1 || f_rd_data !== y) begin bad++; $display("FAIL sim_empty_fwft: got %b/%h exp 1/%h", f_rd_valid, f_rd_data, y); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    total++; if (s_st !== exp_st()) begin bad++; $display("FAIL sim_end: got %b exp %b", s_st, exp_st()); end
  endtask

  task automatic test_fwft();
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    total++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5) begin bad++; $display("FAIL fwft_show: got %b/%h exp 1/a5", f_rd_valid, f_rd_data); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5 || s_rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_hold: got %b/%h std_v=%b", f_rd_valid, f_rd_data, s_rd_valid); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (f_rd_valid !== 1'b0) begin bad++; $display("FAIL fwft_pop: got %b exp 0", f_rd_valid); end
    total++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'hA5) begin bad++; $display("FAIL fwft_std_rd: got %b/%h exp 1/a5", s_rd_valid, s_rd_data); end
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hC3) begin bad++; $display("FAIL fwft_next: got %b/%h exp 1/c3", f_rd_valid, f_rd_data); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      total++; if (s_level !== 4'd1 || f_rd_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap_wr_%0d: got lvl=%0d head=%h", i, s_level, f_rd_data); end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      total++; if (s_level !== 4'd0 || s_rd_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap_rd_%0d: got lvl=%0d d=%h exp 0/%h", i, s_level, s_rd_data, 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] held;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    held = m_sd;
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    total++; if (s_level !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin bad++; $display("FAIL flush_state: got lvl=%0d e=%b f=%b", s_level, s_empty, s_full); end
    total++; if ({s_ovf, s_unf} !== 2'b01) begin bad++; $display("FAIL flush_err: got %b exp 01", {s_ovf, s_unf}); end
    total++; if (s_rd_valid !== 1'b0 || s_rd_data !== held || f_rd_valid !== 1'b0) begin bad++; $display("FAIL flush_rd: got %b/%h fv=%b exp 0/%h/0", s_rd_valid, s_rd_data, f_rd_valid, held); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (s_st !== exp_st() || f_level !== 4'd0) begin bad++; $display("FAIL flush_after: got %b lvl=%0d exp %b", s_st, f_level, exp_st()); end
  endtask

  task automatic test_random();
    logic w, r, fl, ce;
    for (int k = 0; k < 400; k++) begin
      if (((k / 40) % 2) == 0) begin
        w = ($urandom % 4) != 0;
        r = ($urandom % 4) == 0;
      end else begin
        w = ($urandom % 4) == 0;
        r = ($urandom % 4) != 0;
      end
      fl = ($urandom % 50) == 0;
      ce = ($urandom % 8) == 0;
      step(w, 8'($urandom), r, fl, ce);
      total++; if (s_level !== exp_lvl() || f_level !== exp_lvl()) begin bad++; $display("FAIL rnd_level@%0d: got %0d/%0d exp %0d", k, s_level, f_level, exp_lvl()); end
      total++; if (s_st !== exp_st() || f_st !== exp_st()) begin bad++; $display("FAIL rnd_status@%0d: got %b/%b exp %b", k, s_st, f_st, exp_st()); end
      total++; if (s_rd_valid !== m_sv || s_rd_data !== m_sd) begin bad++; $display("FAIL rnd_std@%0d: got %b/%h exp %b/%h", k, s_rd_valid, s_rd_data, m_sv, m_sd); end
      total++; if (f_rd_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_fwft_v@%0d: got %b exp %b", k, f_rd_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if (f_rd_data !== q[0]) begin bad++; $display("FAIL rnd_fwft_d@%0d: got %h exp %h", k, f_rd_data, q[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b1, 8'($urandom) | 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++; if (s_ovf !== 1'b1 || s_rd_data === 8'h00) begin bad++; $display("FAIL rstmid_pre: got ovf=%b d=%h", s_ovf, s_rd_data); end
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h66; flush = 1'b0; clr_err = 1'b0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    total++; if (s_st !== 6'b010100 || f_st !== 6'b010100) begin bad++; $display("FAIL rstmid_status: got %b/%b exp 010100", s_st, f_st); end
    total++; if (s_level !== 4'd0 || {s_rd_valid, s_rd_data} !== 9'h000 || {f_rd_valid, f_rd_data} !== 9'h000) begin bad++; $display("FAIL rstmid_out: lvl=%0d s=%b/%h f=%b/%h", s_level, s_rd_valid, s_rd_data, f_rd_valid, f_rd_data); end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (s_level !== 4'd0 || s_empty !== 1'b1 || f_rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after: got lvl=%0d e=%b fv=%b", s_level, s_empty, f_rd_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_simultaneous();
    test_fwft();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
